train_scheduler: RTL and testbench
==================================

# train_scheduler

Sequences training of one BiasWeight layer stage. It drives the layer's mode and learning-rate inputs, admits exactly NS samples per epoch on the Delta1 stream, and drains in-flight updates before each epoch boundary. After each boundary it decays the learning rate and, after NE epochs, returns the layer to TEST. It sits between the backward-pass source and the layer, and is shared by all neurons of that layer.

## Interface
- WF, 8: fixed-point word width (matches layer WF)
- NS, 16: samples per epoch, ≥1
- NE, 8: epochs per training run, ≥1
- DECAY, 2: halve LR every DECAY epochs, ≥1
- LR_INIT, 8'h40: initial learning rate (signed Q0.WF-1, must be positive)
- MAXINF, 4: maximum accepted-but-unretired samples, ≥1
- iCLK  in  1  clock; one clock domain only
- iRST  in  1  reset, asynchronous, active-high
- iStart  in  1  single-cycle pulse that starts a training run
- oMode  out  1  layer mode, using the TRAIN/TEST encodings from Parameter.vh
- oLR  out  WF  learning rate to the layer
- oEpoch  out  $clog2(NE+1)  completed epochs in the current run
- oDone  out  1  high after a run completes, until the next accepted iStart
- iValid_AS_Delta  in  1  upstream delta valid
- oReady_AS_Delta  out  1  upstream delta ready
- oValid_BM_Delta  out  1  delta valid to the layer
- iReady_BM_Delta  in  1  delta ready from the layer
- iValid_Retire, iReady_Retire  in  1 each  monitor of the layer's weight-output handshake; one handshake = one retired sample

## Operation
- FSM states are IDLE, TRAIN, DRAIN, UPDATE. Reset state is IDLE.
- Reset values: oMode=TEST, oLR=LR_INIT, oEpoch=0, oDone=0, gate closed, all counters 0.
- Gate: open = (state==TRAIN) && (inflight != MAXINF). Both signals are registered.
  - oValid_BM_Delta = iValid_AS_Delta & open.
  - oReady_AS_Delta = iReady_BM_Delta & open.
  - Data passes externally; this block does not carry data.
- acc = oValid_BM_Delta & iReady_BM_Delta.
- ret = iValid_Retire & iReady_Retire.
- inflight update: +1 on acc only; −1 on ret only; unchanged when acc and ret occur together. ret at inflight==0 is ignored (no underflow).
- IDLE:
  - oMode=TEST.
  - iStart → TRAIN; sets epoch=0, scnt=0, oLR=LR_INIT, oDone=0.
- TRAIN:
  - oMode=TRAIN.
  - scnt increments on each acc.
  - acc while scnt==NS−1 → DRAIN, with scnt cleared.
- DRAIN:
  - oMode=TRAIN, gate closed.
  - inflight==0 and no ret this cycle → UPDATE.
- UPDATE, one cycle:
  - epoch+1 is written to oEpoch.
  - If (epoch+1) mod DECAY == 0: oLR ← oLR>>>1, saturating at 1 (never reaches 0).
  - If epoch+1==NE → IDLE, with oDone set and oMode=TEST from the next cycle. Otherwise → TRAIN.
- iStart outside IDLE is ignored.
- Async reset in any state returns to IDLE immediately. In-flight samples are abandoned; the layer is reset by the same iRST.

## Timing
- iStart at edge k: oMode=TRAIN and gate open after edge k+1, so the first acceptance can happen in cycle k+1.
- The gate is combinational AND with registered state, so there is zero added latency on the valid/ready path.
- The NS-th acc and the gate closing occur at the same edge. Exactly NS samples are accepted per epoch, never NS+1.
- DRAIN→UPDATE takes one cycle after inflight reaches 0. UPDATE→TRAIN takes one cycle.
- Minimum epoch overhead is 2 idle cycles plus the layer pipeline latency.
- oLR and oMode change only on the UPDATE exit edge or the IDLE exit edge. They are stable for every sample inside an epoch.
- inflight==MAXINF closes the gate for the following cycle. It reopens the cycle after a ret.

## Test plan
- Reset, then 5 idle cycles: oMode=TEST, oLR=8'h40, oEpoch=0, oDone=0, oReady_AS_Delta=0 even with iReady_BM_Delta=1.
- Run NS=4, NE=3, DECAY=2 with ret 3 cycles after each acc and upstream always valid:
  - exactly 12 accs in total, 4 per epoch;
  - oLR is 8'h40 in epochs 0 and 1, then 8'h20 in epoch 2;
  - oDone rises after the 12th retire plus 2 cycles, with oMode=TEST.
- Layer never retires: at MAXINF=4 the gate closes after 4 accs and no further acc occurs. One ret reopens it for exactly one more acc.
- Same-cycle acc and ret with inflight=2: inflight stays 2. A spurious ret at inflight=0 leaves inflight at 0 and the FSM unaffected.
- Assert iRST mid-DRAIN: the outputs take their reset values asynchronously, before the next iCLK edge. A new iStart then restarts from epoch 0 with LR_INIT.
- LR saturation with LR_INIT=8'h01, DECAY=1, NE=3: oLR stays 8'h01 and never reaches 0. iStart pulses during TRAIN are ignored.

Source files
------------

// File: rtl/train_scheduler.sv
// train_scheduler: sequences one BiasWeight layer stage through a training run.
// Admits exactly NS deltas per epoch, bounds accepted-but-unretired samples to
// MAXINF, drains the layer before each epoch boundary, halves the learning rate
// every DECAY epochs (never below 1) and returns the layer to TEST after NE epochs.
module train_scheduler #(
    parameter int              WF         = 8,
    parameter int              NS         = 16,
    parameter int              NE         = 8,
    parameter int              DECAY      = 2,
    parameter logic [WF-1:0]   LR_INIT    = 8'h40,
    parameter int              MAXINF     = 4,
    parameter logic            MODE_TRAIN = 1'b1,
    parameter logic            MODE_TEST  = 1'b0
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iStart,
    output logic                       oMode,
    output logic [WF-1:0]              oLR,
    output logic [$clog2(NE+1)-1:0]    oEpoch,
    output logic                       oDone,
    input  logic                       iValid_AS_Delta,
    output logic                       oReady_AS_Delta,
    output logic                       oValid_BM_Delta,
    input  logic                       iReady_BM_Delta,
    input  logic                       iValid_Retire,
    input  logic                       iReady_Retire
);

    localparam int EW = $clog2(NE + 1);
    localparam int SW = $clog2(NS + 1);
    localparam int IW = $clog2(MAXINF + 1);
    localparam int DW = $clog2(DECAY + 1);

    localparam logic [SW-1:0] NS_LAST   = SW'(NS - 1);
    localparam logic [EW-1:0] NE_LAST   = EW'(NE - 1);
    localparam logic [IW-1:0] INF_LIMIT = IW'(MAXINF);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAIN,
        S_DRAIN,
        S_UPDATE
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         scnt_q, scnt_d;
    logic [EW-1:0]         epoch_q, epoch_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic [IW-1:0]         inflight_q, inflight_d;
    logic signed [WF-1:0]  lr_q, lr_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;

    logic gate_open;
    logic acc;
    logic ret;
    logic ret_eff;

    // Halve the learning rate with an arithmetic shift; a rate that would
    // shift down to zero (or below) is held at the smallest positive step.
    function automatic logic signed [WF-1:0] lr_halve_sat(input logic signed [WF-1:0] lr);
        logic signed [WF-1:0] shifted;
        shifted = lr >>> 1;
        if (shifted <= '0) begin
            return WF'(1);
        end
        return shifted;
    endfunction

    // The gate only depends on registered state, so valid/ready see no added latency.
    assign gate_open       = (state_q == S_TRAIN) && (inflight_q != INF_LIMIT);
    assign oValid_BM_Delta = iValid_AS_Delta & gate_open;
    assign oReady_AS_Delta = iReady_BM_Delta & gate_open;

    assign acc     = oValid_BM_Delta & iReady_BM_Delta;
    assign ret     = iValid_Retire & iReady_Retire;
    // A retire with nothing outstanding is a monitor glitch and must not underflow.
    assign ret_eff = ret && (inflight_q != '0);

    assign oMode  = mode_q;
    assign oLR    = lr_q;
    assign oEpoch = epoch_q;
    assign oDone  = done_q;

    // Next-state logic for the sequencer, sample/epoch counters and in-flight tracking.
    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        epoch_d    = epoch_q;
        dcnt_d     = dcnt_q;
        lr_d       = lr_q;
        done_d     = done_q;
        inflight_d = inflight_q;

        if (acc && !ret_eff) begin
            inflight_d = inflight_q + 1'b1;
        end else if (ret_eff && !acc) begin
            inflight_d = inflight_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_TRAIN;
                    scnt_d  = '0;
                    epoch_d = '0;
                    dcnt_d  = '0;
                    lr_d    = LR_INIT;
                    done_d  = 1'b0;
                end
            end
            S_TRAIN: begin
                if (acc) begin
                    if (scnt_q == NS_LAST) begin
                        scnt_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Wait until the layer has retired every admitted sample.
                if ((inflight_q == '0) && !ret) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                epoch_d = epoch_q + 1'b1;
                if (dcnt_q == DEC_LAST) begin
                    dcnt_d = '0;
                    lr_d   = lr_halve_sat(lr_q);
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
                if (epoch_q == NE_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_TRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mode_d = (state_d == S_IDLE) ? MODE_TEST : MODE_TRAIN;
    end

    // Sequencer state and registered outputs; reset abandons any run in progress.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            scnt_q     <= '0;
            epoch_q    <= '0;
            dcnt_q     <= '0;
            inflight_q <= '0;
            lr_q       <= LR_INIT;
            mode_q     <= MODE_TEST;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            epoch_q    <= epoch_d;
            dcnt_q     <= dcnt_d;
            inflight_q <= inflight_d;
            lr_q       <= lr_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_train_scheduler.sv
// tb_train_scheduler: directed checks of train_scheduler using two instances,
// A (NS=4, NE=3, DECAY=2, LR_INIT=8'h40, MAXINF=4) and
// B (NS=8, NE=3, DECAY=1, LR_INIT=8'h01, MAXINF=4).
module tb_train_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- instance A ----------------
    logic       start_a, vld_a, rdy_a, auto_a, man_ret_a, mon_a;
    logic       mode_a, done_a, ordy_a, ovld_a, rv_a, rr_a, acc_a;
    logic [7:0] lr_a;
    logic [1:0] ep_a;
    logic [2:0] pipe_a;

    // ---------------- instance B ----------------
    logic       start_b, vld_b, rdy_b, auto_b, man_ret_b, mon_b;
    logic       mode_b, done_b, ordy_b, ovld_b, rv_b, rr_b, acc_b;
    logic [7:0] lr_b;
    logic [1:0] ep_b;
    logic [2:0] pipe_b;

    assign rr_a  = 1'b1;
    assign rr_b  = 1'b1;
    assign acc_a = ovld_a & rdy_a;
    assign acc_b = ovld_b & rdy_b;
    assign rv_a  = (auto_a & pipe_a[2]) | man_ret_a;
    assign rv_b  = (auto_b & pipe_b[2]) | man_ret_b;

    train_scheduler #(.WF(8), .NS(4), .NE(3), .DECAY(2), .LR_INIT(8'h40), .MAXINF(4)) dut_a (
        .iCLK(clk), .iRST(rst), .iStart(start_a),
        .oMode(mode_a), .oLR(lr_a), .oEpoch(ep_a), .oDone(done_a),
        .iValid_AS_Delta(vld_a), .oReady_AS_Delta(ordy_a),
        .oValid_BM_Delta(ovld_a), .iReady_BM_Delta(rdy_a),
        .iValid_Retire(rv_a), .iReady_Retire(rr_a)
    );

    train_scheduler #(.WF(8), .NS(8), .NE(3), .DECAY(1), .LR_INIT(8'h01), .MAXINF(4)) dut_b (
        .iCLK(clk), .iRST(rst), .iStart(start_b),
        .oMode(mode_b), .oLR(lr_b), .oEpoch(ep_b), .oDone(done_b),
        .iValid_AS_Delta(vld_b), .oReady_AS_Delta(ordy_b),
        .oValid_BM_Delta(ovld_b), .iReady_BM_Delta(rdy_b),
        .iValid_Retire(rv_b), .iReady_Retire(rr_b)
    );

    // Layer model: each accepted sample retires 3 cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_a <= '0;
            pipe_b <= '0;
        end else begin
            pipe_a <= {pipe_a[1:0], acc_a};
            pipe_b <= {pipe_b[1:0], acc_b};
        end
    end

    int         acc_tot_a = 0;
    int         acc_ep_a [4] = '{0, 0, 0, 0};
    logic [7:0] lr_ep_a  [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         lr_unstable_a = 0;
    int         last_ret_edge_a = 0;
    int         acc_tot_b = 0;
    int         lr_bad_b = 0;

    // Edge monitor: counts acceptances per epoch and records retire timing.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_a && acc_a) begin
            acc_tot_a <= acc_tot_a + 1;
            acc_ep_a[ep_a] <= acc_ep_a[ep_a] + 1;
            if (acc_ep_a[ep_a] == 0) lr_ep_a[ep_a] <= lr_a;
            else if (lr_ep_a[ep_a] != lr_a) lr_unstable_a <= lr_unstable_a + 1;
        end
        if (mon_a && rv_a && rr_a) last_ret_edge_a <= cyc + 1;
        if (mon_b && acc_b) acc_tot_b <= acc_tot_b + 1;
        if (mon_b && (lr_b != 8'h01)) lr_bad_b <= lr_bad_b + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
    endtask

    int done_edge;

    initial begin
        rst = 1'b1;
        start_a = 0; vld_a = 0; rdy_a = 1; auto_a = 0; man_ret_a = 0; mon_a = 0;
        start_b = 0; vld_b = 0; rdy_b = 1; auto_b = 0; man_ret_b = 0; mon_b = 0;
        done_edge = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state held through idle cycles, downstream ready high.
        repeat (5) @(negedge clk);
        check_eq("rst_mode_a", mode_a, 0);
        check_eq("rst_lr_a", lr_a, 8'h40);
        check_eq("rst_epoch_a", ep_a, 0);
        check_eq("rst_done_a", done_a, 0);
        check_eq("rst_ready_a", ordy_a, 0);
        check_eq("rst_lr_b", lr_b, 8'h01);
        check_eq("rst_ready_b", ordy_b, 0);

        // Full run on A: upstream always valid, retire 3 cycles after accept.
        vld_a = 1; auto_a = 1; mon_a = 1;
        pulse_start_a();
        check_eq("start_mode_a", mode_a, 1);
        check_eq("start_valid_a", ovld_a, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) break;
        end
        done_edge = cyc;
        check_eq("run_done_a", done_a, 1);
        check_eq("run_mode_a", mode_a, 0);
        check_eq("run_epoch_a", ep_a, 3);
        check_eq("run_lr_final_a", lr_a, 8'h20);
        check_eq("run_acc_total_a", acc_tot_a, 12);
        check_eq("run_acc_ep0_a", acc_ep_a[0], 4);
        check_eq("run_acc_ep1_a", acc_ep_a[1], 4);
        check_eq("run_acc_ep2_a", acc_ep_a[2], 4);
        check_eq("run_lr_ep0_a", lr_ep_a[0], 8'h40);
        check_eq("run_lr_ep1_a", lr_ep_a[1], 8'h40);
        check_eq("run_lr_ep2_a", lr_ep_a[2], 8'h20);
        check_eq("run_lr_stable_a", lr_unstable_a, 0);
        check_eq("done_after_ret_a", done_edge - last_ret_edge_a, 2);
        mon_a = 0;

        // B: in-flight limit, simultaneous acc/ret, spurious retire.
        mon_b = 1;
        pulse_start_b();
        vld_b = 1;
        repeat (2) @(posedge clk);
        #1 vld_b = 0;
        @(negedge clk);
        check_eq("infl_two_b", dut_b.inflight_q, 2);
        check_eq("acc_two_b", acc_tot_b, 2);
        vld_b = 1; man_ret_b = 1;
        @(posedge clk);
        #1 vld_b = 0; man_ret_b = 0;
        @(negedge clk);
        check_eq("acc_ret_same_b", dut_b.inflight_q, 2);
        check_eq("acc_three_b", acc_tot_b, 3);
        vld_b = 1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("maxinf_cap_b", acc_tot_b, 5);
        check_eq("maxinf_gate_b", ovld_b, 0);
        check_eq("maxinf_infl_b", dut_b.inflight_q, 4);
        man_ret_b = 1;
        @(posedge clk);
        #1 man_ret_b = 0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("reopen_one_b", acc_tot_b, 6);
        check_eq("reopen_closed_b", ovld_b, 0);
        vld_b = 0; man_ret_b = 1;
        repeat (5) @(posedge clk);
        #1 man_ret_b = 0;
        @(negedge clk);
        check_eq("spurious_ret_b", dut_b.inflight_q, 0);
        check_eq("spurious_mode_b", mode_b, 1);
        check_eq("spurious_ready_b", ordy_b, 1);

        // B: finish the run with LR saturation; iStart during TRAIN ignored.
        auto_b = 1; vld_b = 1; start_b = 1;
        @(posedge clk);
        #1 start_b = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_b) break;
        end
        check_eq("sat_done_b", done_b, 1);
        check_eq("sat_epoch_b", ep_b, 3);
        check_eq("sat_lr_b", lr_b, 8'h01);
        check_eq("sat_lr_never0_b", lr_bad_b, 0);
        check_eq("sat_acc_total_b", acc_tot_b, 24);
        check_eq("sat_mode_b", mode_b, 0);
        mon_b = 0;

        // A: async reset while stuck in DRAIN of epoch 2.
        auto_a = 1;
        pulse_start_a();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ep_a == 2) break;
        end
        auto_a = 0;
        repeat (10) @(negedge clk);
        check_eq("drain_epoch_a", ep_a, 2);
        check_eq("drain_lr_a", lr_a, 8'h20);
        check_eq("drain_mode_a", mode_a, 1);
        check_eq("drain_gate_a", ordy_a, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_mode_a", mode_a, 0);
        check_eq("arst_lr_a", lr_a, 8'h40);
        check_eq("arst_epoch_a", ep_a, 0);
        check_eq("arst_done_b", done_b, 0);
        check_eq("arst_epoch_b", ep_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        auto_a = 1;
        pulse_start_a();
        check_eq("restart_mode_a", mode_a, 1);
        check_eq("restart_epoch_a", ep_a, 0);
        check_eq("restart_lr_a", lr_a, 8'h40);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ep_a == 1) break;
        end
        check_eq("restart_epoch1_a", ep_a, 1);
        check_eq("restart_lr1_a", lr_a, 8'h40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
